// File: rtl/aes_spi_pkg.sv
// Frame geometry and FSM encoding shared by the AES SPI initiator and responder.
package aes_spi_pkg;
    localparam int AES_SPI_TX_BITS = 256;
    localparam int AES_SPI_RX_BITS = 128;
    localparam int AES_SPI_FRAME   = AES_SPI_TX_BITS + AES_SPI_RX_BITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        TRAIL = 2'd2,
        GAP   = 2'd3
    } spi_state_t;
endpackage

// File: rtl/spi_clk_div.sv
// Half-period divider: one rise_tick/fall_tick pulse every CLK_DIV cycles while enabled, rise first.
// Ticks are combinational on the last count so the caller registers sck on that same edge; no backpressure.
module spi_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic rise_tick,
    output logic fall_tick
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;
    logic          phase;
    logic          wrap;

    assign wrap      = (cnt == CW'(CLK_DIV - 1));
    assign rise_tick = en && wrap && !phase;
    assign fall_tick = en && wrap && phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (clr) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (en) begin
            if (wrap) begin
                cnt   <= '0;
                phase <= ~phase;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/spi_frame_master.sv
// SPI initiator: one fixed frame of TX_BITS out on mosi then RX_BITS in on miso; cs active-high, sck idle low.
// Frame takes CLK_DIV*(2*(TX_BITS+RX_BITS)+1) cycles plus CS_GAP; start is ignored (not queued) while busy.
module spi_frame_master
    import aes_spi_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int TX_BITS = AES_SPI_TX_BITS,
    parameter int RX_BITS = AES_SPI_RX_BITS,
    parameter int CS_GAP  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [TX_BITS-1:0] tx_data,
    output logic               busy,
    output logic               done,
    output logic [RX_BITS-1:0] rx_data,
    output logic               sck,
    output logic               mosi,
    input  logic               miso,
    output logic               cs
);
    localparam int NBITS = TX_BITS + RX_BITS;
    localparam int BCW   = $clog2(NBITS);
    localparam int WMAX  = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int WW    = $clog2(WMAX + 1);

    spi_state_t         state;
    logic [TX_BITS-2:0] tx_sr;
    logic [RX_BITS-1:0] rx_sr;
    logic [BCW-1:0]     bit_cnt;
    logic [WW-1:0]      wcnt;
    logic               rise_tick;
    logic               fall_tick;

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clk       (clk),
        .rst       (rst),
        .en        (state == SHIFT),
        .clr       (state != SHIFT),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cs      <= 1'b0;
            sck     <= 1'b0;
            mosi    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rx_data <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            bit_cnt <= '0;
            wcnt    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // MSB goes straight to mosi; the rest waits in the shift register.
                        mosi    <= tx_data[TX_BITS-1];
                        tx_sr   <= tx_data[TX_BITS-2:0];
                        cs      <= 1'b1;
                        busy    <= 1'b1;
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (rise_tick) begin
                        sck <= 1'b1;
                    end
                    if (fall_tick) begin
                        // Zero fill makes mosi idle low once the payload is exhausted.
                        sck   <= 1'b0;
                        mosi  <= tx_sr[TX_BITS-2];
                        tx_sr <= {tx_sr[TX_BITS-3:0], 1'b0};
                        if (bit_cnt >= BCW'(TX_BITS)) begin
                            rx_sr <= {rx_sr[RX_BITS-2:0], miso};
                        end
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == BCW'(NBITS - 1)) begin
                            wcnt  <= '0;
                            state <= TRAIL;
                        end
                    end
                end
                TRAIL: begin
                    if (wcnt == WW'(CLK_DIV - 1)) begin
                        cs      <= 1'b0;
                        done    <= 1'b1;
                        rx_data <= rx_sr;
                        wcnt    <= '0;
                        state   <= GAP;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                GAP: begin
                    if (wcnt == WW'(CS_GAP - 1)) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_frame_master.sv
// Bench for spi_frame_master at CLK_DIV=4 (index 0) and CLK_DIV=2 (index 1) with a behavioural SPI responder.
module tb_spi_frame_master;
    localparam int TXB = 256;
    localparam int RXB = 128;
    localparam int NB  = TXB + RXB;
    localparam int GAPC = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           start   [2];
    logic [TXB-1:0] tx_data [2];
    logic           busy    [2];
    logic           done    [2];
    logic [RXB-1:0] rx_data [2];
    logic           sck     [2];
    logic           mosi    [2];
    logic           miso    [2];
    logic           cs      [2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_frame_master #(.CLK_DIV(4), .TX_BITS(TXB), .RX_BITS(RXB), .CS_GAP(GAPC)) u_dut4 (
        .clk(clk), .rst(rst), .start(start[0]), .tx_data(tx_data[0]), .busy(busy[0]),
        .done(done[0]), .rx_data(rx_data[0]), .sck(sck[0]), .mosi(mosi[0]),
        .miso(miso[0]), .cs(cs[0]));

    spi_frame_master #(.CLK_DIV(2), .TX_BITS(TXB), .RX_BITS(RXB), .CS_GAP(GAPC)) u_dut2 (
        .clk(clk), .rst(rst), .start(start[1]), .tx_data(tx_data[1]), .busy(busy[1]),
        .done(done[1]), .rx_data(rx_data[1]), .sck(sck[1]), .mosi(mosi[1]),
        .miso(miso[1]), .cs(cs[1]));

    typedef struct {
        int             d;
        logic [TXB-1:0] tx;
        logic [RXB-1:0] out;
        logic [RXB-1:0] exp_rx;
    } vec_t;

    vec_t vecs [7];

    function automatic int cdiv(input int d);
        return (d == 0) ? 4 : 2;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Request a frame and check the first registered cycle; tx_data is then scrambled.
    task automatic accept(input int d, input logic [TXB-1:0] txv);
        @(negedge clk);
        tx_data[d] = txv;
        start[d]   = 1'b1;
        @(negedge clk);
        start[d]   = 1'b0;
        tx_data[d] = ~txv;
        chk1("accept_cs", cs[d], 1'b1);
        chk1("accept_busy", busy[d], 1'b1);
        chk1("accept_mosi", mosi[d], txv[TXB-1]);
        chk1("accept_sck", sck[d], 1'b0);
    endtask

    task automatic run_frame(input int d, input logic [TXB-1:0] txv, input logic [RXB-1:0] outv,
                             input logic [RXB-1:0] exp_rx, input bit pulse);
        int t0, rises, first_rise, done_at, done_cnt, stable_bad, zero_bad, gap, budget, cs_seen;
        logic prev_sck, hold, rose, cs_done;
        logic [TXB-1:0] cap;
        logic [RXB-1:0] rx_done;
        accept(d, txv);
        t0 = cyc; rises = 0; first_rise = -1; done_at = -1; done_cnt = 0;
        stable_bad = 0; zero_bad = 0; gap = -1; prev_sck = 1'b0; hold = 1'b0;
        cap = '0; rx_done = '0; cs_done = 1'b1;
        budget = cdiv(d) * 2 * NB + 60;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            rose = 1'b0;
            if (sck[d] && !prev_sck) begin
                rose = 1'b1;
                if (rises == 0) first_rise = cyc - t0;
                if (rises < TXB) begin
                    cap[TXB-1-rises] = mosi[d];
                end else if (rises < NB) begin
                    if (mosi[d] !== 1'b0) zero_bad++;
                    miso[d] = outv[RXB-1-(rises-TXB)];
                end
                hold = mosi[d];
                rises++;
            end else if (sck[d] && mosi[d] !== hold) begin
                stable_bad++;
            end
            prev_sck = sck[d];
            if (done[d]) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = cyc - t0;
                    rx_done = rx_data[d];
                    cs_done = cs[d];
                end
            end
            start[d] = pulse && ((rose && (rises == 11 || rises == NB)) ||
                                 (done_at >= 0 && cyc - t0 == done_at));
            if (done_at >= 0 && !busy[d]) begin
                gap = cyc - t0 - done_at;
                break;
            end
        end
        start[d] = 1'b0;
        chkn("first_rise", first_rise, cdiv(d));
        chkn("rise_count", rises, NB);
        chk("mosi_capture", cap, txv);
        chkn("mosi_zero_tail", zero_bad, 0);
        chkn("mosi_stable", stable_bad, 0);
        chkn("done_time", done_at, cdiv(d) * (2 * NB + 1));
        chkn("done_pulses", done_cnt, 1);
        chk("rx_data", 256'(rx_done), 256'(exp_rx));
        chk1("cs_at_done", cs_done, 1'b0);
        chk1("gap_len_ok", gap >= GAPC, 1'b1);
        cs_seen = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (cs[d]) cs_seen++;
        end
        chk("rx_hold", 256'(rx_data[d]), 256'(exp_rx));
        if (pulse) chkn("busy_start_ignored", cs_seen, 0);
    endtask

    initial begin
        logic [TXB-1:0] seq_tx;
        logic [TXB-1:0] aa_tx;
        logic [TXB-1:0] ones_tx;
        logic           prev;
        int             rises, saw_done, saw_cs;
        int             cs_rises, dones, wide, low_run, min_low;
        logic           prev_cs, prev_done;

        seq_tx  = 256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F;
        aa_tx   = {32{8'hAA}};
        ones_tx = '1;

        vecs[0] = '{0, seq_tx, 128'hDEADBEEF_00112233_44556677_8899AABB,
                    128'hDEADBEEF_00112233_44556677_8899AABB};
        vecs[1] = '{0, ones_tx, '0, '0};
        vecs[2] = '{0, aa_tx, '1, '1};
        vecs[3] = '{1, seq_tx, 128'hDEADBEEF_00112233_44556677_8899AABB,
                    128'hDEADBEEF_00112233_44556677_8899AABB};
        for (int i = 4; i < 7; i++) begin
            vecs[i].d = int'($urandom_range(1, 0));
            for (int w = 0; w < 8; w++) vecs[i].tx[w*32 +: 32] = $urandom;
            for (int w = 0; w < 4; w++) vecs[i].out[w*32 +: 32] = $urandom;
            vecs[i].exp_rx = vecs[i].out;
        end

        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            start[d] = 1'b0; tx_data[d] = '0; miso[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk1("reset_cs", cs[d], 1'b0);
            chk1("reset_sck", sck[d], 1'b0);
            chk1("reset_mosi", mosi[d], 1'b0);
            chk1("reset_busy", busy[d], 1'b0);
            chk1("reset_done", done[d], 1'b0);
            chk("reset_rx", 256'(rx_data[d]), '0);
        end
        rst = 1'b0;

        // Abort in the middle of bit 100 while sck and mosi are both high.
        accept(0, ones_tx);
        rises = 0; prev = 1'b0;
        for (int n = 0; n < 4 * 2 * 110 && rises < 101; n++) begin
            @(negedge clk);
            if (sck[0] && !prev) rises++;
            prev = sck[0];
        end
        chkn("abort_bit", rises, 101);
        rst = 1'b1;
        #1;
        chk1("abort_cs", cs[0], 1'b0);
        chk1("abort_sck", sck[0], 1'b0);
        chk1("abort_mosi", mosi[0], 1'b0);
        chk1("abort_busy", busy[0], 1'b0);
        saw_done = 0; saw_cs = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (n == 2) rst = 1'b0;
            if (done[0]) saw_done++;
            if (cs[0]) saw_cs++;
        end
        chkn("abort_no_done", saw_done, 0);
        chkn("abort_no_cs", saw_cs, 0);

        for (int i = 0; i < 7; i++) begin
            run_frame(vecs[i].d, vecs[i].tx, vecs[i].out, vecs[i].exp_rx, 1'b0);
        end

        run_frame(0, seq_tx, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
                  128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1'b1);

        // start held high: two frames separated by a cs-low gap.
        @(negedge clk);
        tx_data[1] = aa_tx; start[1] = 1'b1; miso[1] = 1'b1;
        cs_rises = 0; dones = 0; wide = 0; low_run = 0; min_low = 1000;
        prev_cs = 1'b0; prev_done = 1'b0;
        for (int n = 0; n < 2 * (2 * 2 * NB + 40); n++) begin
            @(negedge clk);
            if (cs[1] && !prev_cs) begin
                cs_rises++;
                if (cs_rises > 1 && low_run < min_low) min_low = low_run;
            end
            low_run = cs[1] ? 0 : low_run + 1;
            if (done[1]) begin
                if (prev_done) wide++;
                else dones++;
            end
            prev_cs = cs[1];
            prev_done = done[1];
            if (dones == 2) start[1] = 1'b0;
            if (dones == 2 && !busy[1]) break;
        end
        start[1] = 1'b0;
        chkn("b2b_frames", cs_rises, 2);
        chkn("b2b_done", dones, 2);
        chkn("b2b_done_wide", wide, 0);
        chk1("b2b_gap_ok", min_low >= GAPC && min_low < 1000, 1'b1);
        chk("b2b_rx", 256'(rx_data[1]), 256'({RXB{1'b1}}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
